tie_release_sequencer: RTL and testbench

- Holds a bank of N_CH configuration/control outputs at a safe tied value (TIE_VAL, sourced by tie cells at the pad/macro boundary) from reset until the outputs are released one at a time.
- Release is in ascending channel order, with a programmable settle gap between channels. Re-tie happens in descending order.
- Sits between the power/boot controller and tie-protected macro inputs, so no two channels switch from tied to functional in the same cycle.

---
 rtl/tie_release_sequencer.sv | 119 +++++++++++
 tb/tb_tie_release_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tie_release_sequencer.sv
// Sequences a bank of tie-protected outputs from their tied value to functional
// values one channel at a time, with a programmable settle gap between steps.
module tie_release_sequencer #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 8,
   parameter bit TIE_VAL = 1'b1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             EN_REQ,
   input  logic             FORCE_TIE,
   input  logic [CNT_W-1:0] DLY,
   input  logic [N_CH-1:0]  D,
   output logic [N_CH-1:0]  Z,
   output logic [N_CH-1:0]  REL,
   output logic             BUSY,
   output logic             ACK
);

   localparam int NREL_W = $clog2(N_CH + 1);
   localparam logic [NREL_W-1:0] NREL_MAX = NREL_W'(N_CH);

   typedef enum logic [1:0] {S_TIED, S_RAMP, S_ON} state_t;

   state_t              r_state, w_state_next;
   logic [N_CH-1:0]     r_rel, w_rel_next;
   logic [NREL_W-1:0]   r_nrel, w_nrel_next;
   logic [CNT_W-1:0]    r_timer, w_timer_next;
   logic                r_dir, w_dir_next;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= S_TIED;
         r_rel   <= '0;
         r_nrel  <= '0;
         r_timer <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_rel   <= w_rel_next;
         r_nrel  <= w_nrel_next;
         r_timer <= w_timer_next;
         r_dir   <= w_dir_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rel_next   = r_rel;
      w_nrel_next  = r_nrel;
      w_timer_next = r_timer;
      w_dir_next   = r_dir;
      if (FORCE_TIE) begin
         w_state_next = S_TIED;
         w_rel_next   = '0;
         w_nrel_next  = '0;
      end else begin
         case (r_state)
            S_TIED: begin
               if (EN_REQ) begin
                  w_state_next = S_RAMP;
                  w_dir_next   = 1'b1;
                  w_timer_next = DLY;
               end
            end
            S_RAMP: begin
               // A reversal only reloads the timer; the next step waits a full gap.
               if (EN_REQ != r_dir) begin
                  w_dir_next   = EN_REQ;
                  w_timer_next = DLY;
                  if (!EN_REQ && r_nrel == '0)
                     w_state_next = S_TIED;
                  else if (EN_REQ && r_nrel == NREL_MAX)
                     w_state_next = S_ON;
               end else if (r_timer != '0) begin
                  w_timer_next = r_timer - 1'b1;
               end else begin
                  w_timer_next = DLY;
                  if (r_dir) begin
                     w_rel_next  = {r_rel[N_CH-2:0], 1'b1};
                     w_nrel_next = r_nrel + 1'b1;
                     if (r_nrel == NREL_MAX - 1'b1)
                        w_state_next = S_ON;
                  end else begin
                     w_rel_next  = r_rel >> 1;
                     w_nrel_next = r_nrel - 1'b1;
                     if (r_nrel == NREL_W'(1))
                        w_state_next = S_TIED;
                  end
               end
            end
            S_ON: begin
               if (!EN_REQ) begin
                  w_state_next = S_RAMP;
                  w_dir_next   = 1'b0;
                  w_timer_next = DLY;
               end
            end
            default: begin
               w_state_next = S_TIED;
               w_rel_next   = '0;
               w_nrel_next  = '0;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_out
         assign Z[gi] = r_rel[gi] ? D[gi] : TIE_VAL;
      end
   endgenerate

   assign REL  = r_rel;
   assign BUSY = (r_state == S_RAMP);
   assign ACK  = (r_state == S_ON);

endmodule

// File: tb/tb_tie_release_sequencer.sv
// Directed bench for tie_release_sequencer: ramps, reversal, force-tie, async reset, delay extremes.
module tb_tie_release_sequencer;

   localparam int N_CH  = 4;
   localparam int CNT_W = 8;

   logic             CLK = 1'b0;
   logic             RN = 1'b0;
   logic             EN_REQ = 1'b0;
   logic             FORCE_TIE = 1'b0;
   logic [CNT_W-1:0] DLY = '0;
   logic [N_CH-1:0]  D = '0;
   logic [N_CH-1:0]  Z;
   logic [N_CH-1:0]  REL;
   logic             BUSY;
   logic             ACK;

   int n_cmp = 0;
   int n_err = 0;

   tie_release_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .TIE_VAL(1'b1)) dut (
      .CLK(CLK), .RN(RN), .EN_REQ(EN_REQ), .FORCE_TIE(FORCE_TIE), .DLY(DLY),
      .D(D), .Z(Z), .REL(REL), .BUSY(BUSY), .ACK(ACK)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance n rising edges, then settle 1ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      check_val("rst_rel", 32'(REL), 32'h0);
      check_val("rst_z", 32'(Z), 32'hF);
      check_val("rst_busy", 32'(BUSY), 32'h0);
      check_val("rst_ack", 32'(ACK), 32'h0);
      tick(2);
      RN = 1'b1;
      tick(1);

      // 1: up-ramp, DLY=3
      DLY = 8'd3; D = 4'b0000; EN_REQ = 1'b1;
      tick(1);
      check_val("up_k_busy", 32'(BUSY), 32'h1);
      tick(3);
      check_val("up_k3_rel", 32'(REL), 32'h0);
      tick(1);
      check_val("up_k4_rel", 32'(REL), 32'h1);
      check_val("up_k4_z", 32'(Z), 32'hE);
      tick(4);
      check_val("up_k8_rel", 32'(REL), 32'h3);
      check_val("up_k8_z", 32'(Z), 32'hC);
      tick(4);
      check_val("up_k12_rel", 32'(REL), 32'h7);
      tick(3);
      check_val("up_k15_ack", 32'(ACK), 32'h0);
      tick(1);
      check_val("up_k16_rel", 32'(REL), 32'hF);
      check_val("up_k16_ack", 32'(ACK), 32'h1);
      check_val("up_k16_busy", 32'(BUSY), 32'h0);
      D = 4'b1010; #1;
      check_val("on_z_pass", 32'(Z), 32'hA);

      // 2: down-ramp from ON
      D = 4'b0000; EN_REQ = 1'b0;
      tick(1);
      check_val("dn_m_busy", 32'(BUSY), 32'h1);
      check_val("dn_m_ack", 32'(ACK), 32'h0);
      tick(3);
      check_val("dn_m3_rel", 32'(REL), 32'hF);
      tick(1);
      check_val("dn_m4_rel", 32'(REL), 32'h7);
      tick(4);
      check_val("dn_m8_rel", 32'(REL), 32'h3);
      tick(4);
      check_val("dn_m12_rel", 32'(REL), 32'h1);
      tick(4);
      check_val("dn_m16_rel", 32'(REL), 32'h0);
      check_val("dn_m16_busy", 32'(BUSY), 32'h0);
      check_val("dn_m16_z", 32'(Z), 32'hF);

      // 3: reversal, DLY=2
      DLY = 8'd2; EN_REQ = 1'b1;
      tick(1);
      tick(6);
      check_val("rv_up_rel", 32'(REL), 32'h3);
      EN_REQ = 1'b0;
      tick(1);
      check_val("rv_edge_rel", 32'(REL), 32'h3);
      check_val("rv_edge_busy", 32'(BUSY), 32'h1);
      tick(2);
      check_val("rv_hold_rel", 32'(REL), 32'h3);
      tick(1);
      check_val("rv_dn1_rel", 32'(REL), 32'h1);
      tick(3);
      check_val("rv_dn0_rel", 32'(REL), 32'h0);
      check_val("rv_dn0_busy", 32'(BUSY), 32'h0);
      EN_REQ = 1'b1;
      tick(4);
      check_val("rr_up1_rel", 32'(REL), 32'h1);
      tick(3);
      check_val("rr_up2_rel", 32'(REL), 32'h3);
      EN_REQ = 1'b0;
      tick(4);
      check_val("rr_dn_rel", 32'(REL), 32'h1);
      EN_REQ = 1'b1;
      tick(3);
      check_val("rr_resume_hold", 32'(REL), 32'h1);
      tick(1);
      check_val("rr_resume_rel", 32'(REL), 32'h3);
      tick(3);
      check_val("ft_pre_rel", 32'(REL), 32'h7);

      // 4: FORCE_TIE
      FORCE_TIE = 1'b1;
      tick(1);
      check_val("ft_rel", 32'(REL), 32'h0);
      check_val("ft_z", 32'(Z), 32'hF);
      check_val("ft_busy", 32'(BUSY), 32'h0);
      tick(10);
      check_val("ft_held_rel", 32'(REL), 32'h0);
      check_val("ft_held_busy", 32'(BUSY), 32'h0);
      FORCE_TIE = 1'b0;
      tick(1);
      check_val("ft_restart_busy", 32'(BUSY), 32'h1);
      tick(2);
      check_val("ft_restart_k2", 32'(REL), 32'h0);
      tick(1);
      check_val("ft_restart_k3", 32'(REL), 32'h1);
      tick(9);
      check_val("ft_on_ack", 32'(ACK), 32'h1);

      // 5: async reset mid-cycle while ON
      DLY = 8'd3;
      #3;
      RN = 1'b0;
      #1;
      check_val("ar_z", 32'(Z), 32'hF);
      check_val("ar_rel", 32'(REL), 32'h0);
      check_val("ar_ack", 32'(ACK), 32'h0);
      @(posedge CLK); #1;
      RN = 1'b1;
      tick(1);
      check_val("ar_restart_busy", 32'(BUSY), 32'h1);
      tick(3);
      check_val("ar_k3_rel", 32'(REL), 32'h0);
      tick(1);
      check_val("ar_k4_rel", 32'(REL), 32'h1);

      // 6: DLY=0 then DLY=255 with a mid-gap change
      FORCE_TIE = 1'b1;
      tick(1);
      FORCE_TIE = 1'b0; DLY = 8'd0;
      tick(1);
      tick(1);
      check_val("d0_k1_rel", 32'(REL), 32'h1);
      tick(1);
      check_val("d0_k2_rel", 32'(REL), 32'h3);
      tick(2);
      check_val("d0_k4_rel", 32'(REL), 32'hF);
      check_val("d0_k4_ack", 32'(ACK), 32'h1);
      DLY = 8'd255; EN_REQ = 1'b0;
      tick(1);
      tick(255);
      check_val("d255_m255_rel", 32'(REL), 32'hF);
      tick(1);
      check_val("d255_m256_rel", 32'(REL), 32'h7);
      tick(10);
      DLY = 8'd5;
      tick(245);
      check_val("dchg_m511_rel", 32'(REL), 32'h7);
      tick(1);
      check_val("dchg_m512_rel", 32'(REL), 32'h3);
      tick(5);
      check_val("dchg_gap5_hold", 32'(REL), 32'h3);
      tick(1);
      check_val("dchg_gap5_rel", 32'(REL), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
